// File: rtl/wb_imem_loader.sv
// wb_imem_loader
//   Wishbone slave in front of the 32x256 instruction SRAM. In load mode the
//   bus owns the single SRAM port so the management SoC can load and read back
//   program words while the core is held in init. In run mode the core's port
//   is passed straight through to the SRAM.
//
// Ports
//   wb_clk_i, wb_rst_ni         clock, synchronous active-low reset
//   wbs_*                       Wishbone slave (cyc/stb/we/sel/adr/dat, ack/dat_o)
//   core_addr_i/wr_i/din_i      core memory port (wr_i is an active-low web)
//   init_en_o                   holds the core in init while high (= load_mode)
//   sram_*0_*                   SRAM port 0 (csb/web active-low, read data
//                               valid the cycle after the read edge)
//
// Register map (byte offsets from BASE_ADR)
//   0x000-0x3FC  SRAM window, word = adr[9:2]
//   0x400        CTRL   bit0 = load_mode (R/W)
//   0x404        STATUS [8:0] = wr_count, [24:16] = rej_count (RO)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a hit; the only state that samples requests
// WR       | one-cycle SRAM write strobe, ack high in this cycle
// RD_ISSUE | SRAM read strobe
// RD_WAIT  | SRAM data valid, captured into wbs_dat_o
// ACK      | one-cycle ack for reads, register access and rejects
module wb_imem_loader #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          AW       = 8,
  parameter int          DW       = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic [AW-1:0] core_addr_i,
  input  logic          core_wr_i,
  input  logic [DW-1:0] core_din_i,
  output logic          init_en_o,
  output logic          sram_csb0_o,
  output logic          sram_web0_o,
  output logic [AW-1:0] sram_addr0_o,
  output logic [DW-1:0] sram_din0_o,
  input  logic [DW-1:0] sram_dout0_i
);

  localparam logic [8:0] OFF_CTRL   = 9'h100;
  localparam logic [8:0] OFF_STATUS = 9'h101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t        state;
  logic          load_mode;
  logic [8:0]    wr_count;
  logic [8:0]    rej_count;
  logic [AW-1:0] lat_word;
  logic [DW-1:0] lat_dat;
  logic          lat_ctrl_wr;

  logic          hit;
  logic          is_sram;
  logic [8:0]    reg_off;
  logic [31:0]   status_val;
  logic          bus_sel;

  // byte-lane bits of the address carry no information for word accesses
  logic unused_adr_bits;
  assign unused_adr_bits = &{1'b0, wbs_adr_i[1:0]};

  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:11] == BASE_ADR[31:11]);
  assign is_sram    = ~wbs_adr_i[10];
  assign reg_off    = wbs_adr_i[10:2];
  assign status_val = {7'd0, rej_count, 7'd0, wr_count};
  assign init_en_o  = load_mode;

  // Any transaction past IDLE keeps the bus mux selected, so a transaction
  // always finishes on the side that owned the port when it was accepted.
  assign bus_sel = load_mode | (state != IDLE);

  always_comb begin
    sram_csb0_o  = 1'b1;
    sram_web0_o  = 1'b1;
    sram_addr0_o = lat_word;
    sram_din0_o  = lat_dat;
    if (!bus_sel) begin
      sram_csb0_o  = 1'b0;
      sram_web0_o  = core_wr_i;
      sram_addr0_o = core_addr_i;
      sram_din0_o  = core_din_i;
    end else begin
      case (state)
        WR: begin
          sram_csb0_o = 1'b0;
          sram_web0_o = 1'b0;
        end
        RD_ISSUE: begin
          sram_csb0_o = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'd0;
      load_mode   <= 1'b1;
      wr_count    <= 9'd0;
      rej_count   <= 9'd0;
      lat_word    <= '0;
      lat_dat     <= '0;
      lat_ctrl_wr <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            lat_word    <= wbs_adr_i[AW+1:2];
            lat_dat     <= wbs_dat_i;
            lat_ctrl_wr <= 1'b0;
            if (!is_sram) begin
              state     <= ACK;
              wbs_ack_o <= 1'b1;
              if (wbs_we_i) begin
                lat_ctrl_wr <= (reg_off == OFF_CTRL);
              end else begin
                case (reg_off)
                  OFF_CTRL:   wbs_dat_o <= {31'd0, load_mode};
                  OFF_STATUS: wbs_dat_o <= status_val;
                  default:    wbs_dat_o <= 32'd0;
                endcase
              end
            end else if (!load_mode || (wbs_we_i && wbs_sel_i != 4'hF)) begin
              // core owns the SRAM, or a partial write the macro cannot mask
              state     <= ACK;
              wbs_ack_o <= 1'b1;
              if (rej_count != 9'h1FF) rej_count <= rej_count + 9'd1;
              if (!load_mode && !wbs_we_i) wbs_dat_o <= 32'd0;
            end else if (wbs_we_i) begin
              state     <= WR;
              wbs_ack_o <= 1'b1;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end
        WR: begin
          if (wr_count != 9'h1FF) wr_count <= wr_count + 9'd1;
          state <= IDLE;
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          wbs_dat_o <= sram_dout0_i;
          wbs_ack_o <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          if (lat_ctrl_wr) load_mode <= lat_dat[0];
          lat_ctrl_wr <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_imem_loader.sv
module tb_wb_imem_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  core_addr;
  logic        core_wr;
  logic [31:0] core_din;
  logic        init_en;
  logic        csb, web;
  logic [7:0]  s_addr;
  logic [31:0] s_din, s_dout;

  wb_imem_loader #(.BASE_ADR(BASE), .AW(8), .DW(32)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .core_addr_i (core_addr),
    .core_wr_i   (core_wr),
    .core_din_i  (core_din),
    .init_en_o   (init_en),
    .sram_csb0_o (csb),
    .sram_web0_o (web),
    .sram_addr0_o(s_addr),
    .sram_din0_o (s_din),
    .sram_dout0_i(s_dout)
  );

  always #5 clk = ~clk;

  // SRAM macro: synchronous, read data valid the cycle after the read edge
  logic [31:0] sram_mem [256];
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) sram_mem[s_addr] <= s_din;
      else      s_dout <= sram_mem[s_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] ref_mem [256];
  logic        exp_load = 1'b1;
  logic [8:0]  wr_m = 9'd0;
  logic [8:0]  rej_m = 9'd0;
  logic [31:0] exp_dat = 32'd0;
  logic        busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] sat9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  // Every cycle out of reset: init_en tracks load mode, no stray acks, read
  // data holds, and the SRAM port is idle or passes the core through.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("init_en", {31'd0, init_en}, {31'd0, exp_load});
      if (!busy) begin
        chk("idle_ack", {31'd0, ack}, 32'd0);
        chk("dat_hold", rdat, exp_dat);
        if (exp_load) begin
          chk("bus_idle_csb", {31'd0, csb}, 32'd1);
        end else begin
          chk("core_csb", {31'd0, csb}, 32'd0);
          chk("core_web", {31'd0, web}, {31'd0, core_wr});
          chk("core_addr", {24'd0, s_addr}, {24'd0, core_addr});
          chk("core_din", s_din, core_din);
        end
      end
    end
  end

  task automatic bus_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd);
    logic [7:0] word;
    logic [8:0] off;
    int exp_lat, exp_pulses, lat, pulses;
    logic [31:0] exp_rd;
    logic ctrl_wr;
    word = a[9:2];
    off = a[10:2];
    exp_lat = 1;
    exp_pulses = 0;
    exp_rd = 32'd0;
    ctrl_wr = 1'b0;
    if (!a[10]) begin
      if (!exp_load) begin
        rej_m = sat9(rej_m);
      end else if (w && s != 4'hF) begin
        rej_m = sat9(rej_m);
      end else if (w) begin
        exp_pulses = 1;
        ref_mem[word] = d;
        wr_m = sat9(wr_m);
      end else begin
        exp_lat = 3;
        exp_rd = ref_mem[word];
      end
    end else if (w) begin
      ctrl_wr = (off == 9'h100);
    end else if (off == 9'h100) begin
      exp_rd = {31'd0, exp_load};
    end else if (off == 9'h101) begin
      exp_rd = {7'd0, rej_m, 7'd0, wr_m};
    end

    @(negedge clk);
    busy = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    lat = 0;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!csb && !web) begin
        pulses++;
        chk("wr_addr", {24'd0, s_addr}, {24'd0, word});
        chk("wr_din", s_din, d);
      end
      if (ack) begin
        lat = c;
        break;
      end
    end
    rd = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (lat == 0) begin
      failures++;
      $display("FAIL ack_timeout: no ack within 8 cycles for adr %h", a);
    end else begin
      chk("ack_latency", lat, exp_lat);
      chk("wr_pulses", pulses, exp_pulses);
      if (!w) begin
        chk("rd_data", rdat, exp_rd);
        exp_dat = exp_rd;
      end
    end
    @(posedge clk);
    if (ctrl_wr) exp_load = d[0];
    busy = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    core_addr = 8'd0; core_wr = 1'b1; core_din = 32'd0;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_init_en", {31'd0, init_en}, 32'd1);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_csb", {31'd0, csb}, 32'd1);
    rst_n = 1'b1;

    bus_xfer(BASE + 32'h404, 1'b0, 4'hF, 32'd0, r);
    chk("lit_status_rst", r, 32'h0000_0000);

    bus_xfer(BASE + 32'h014, 1'b1, 4'hF, 32'hDEAD_BEEF, r);
    bus_xfer(BASE + 32'h404, 1'b0, 4'hF, 32'd0, r);
    chk("lit_status_wr1", r, 32'h0000_0001);
    bus_xfer(BASE + 32'h014, 1'b0, 4'hF, 32'd0, r);
    chk("lit_rd_word5", r, 32'hDEAD_BEEF);

    bus_xfer(BASE + 32'h000, 1'b1, 4'hF, 32'h1234_5678, r);
    bus_xfer(BASE + 32'h3FC, 1'b1, 4'hF, 32'hA5A5_0FF0, r);
    bus_xfer(BASE + 32'h3FC, 1'b0, 4'hF, 32'd0, r);
    chk("lit_rd_word255", r, 32'hA5A5_0FF0);
    bus_xfer(BASE + 32'h000, 1'b0, 4'hF, 32'd0, r);

    bus_xfer(BASE + 32'h018, 1'b1, 4'h3, 32'hCAFE_F00D, r);
    bus_xfer(BASE + 32'h018, 1'b0, 4'hF, 32'd0, r);
    chk("lit_rd_masked", r, 32'h0000_0000);
    bus_xfer(BASE + 32'h404, 1'b0, 4'hF, 32'd0, r);
    chk("lit_status_rej", r, 32'h0001_0003);

    bus_xfer(BASE + 32'h400, 1'b0, 4'hF, 32'd0, r);
    chk("lit_ctrl_load", r, 32'h0000_0001);
    bus_xfer(BASE + 32'h408, 1'b1, 4'hF, 32'hFFFF_FFFF, r);
    bus_xfer(BASE + 32'h408, 1'b0, 4'hF, 32'd0, r);

    // address outside the block: never acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 32'h4000_0014; we = 1'b0; sel = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("miss_no_ack", {31'd0, ack}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // hand the SRAM to the core
    bus_xfer(BASE + 32'h400, 1'b1, 4'hF, 32'h0000_0000, r);
    @(negedge clk);
    chk("lit_init_run", {31'd0, init_en}, 32'd0);
    core_addr = 8'h2A; core_din = 32'h0BAD_F00D; core_wr = 1'b0;
    @(negedge clk);
    chk("lit_core_addr", {24'd0, s_addr}, 32'h0000_002A);
    core_wr = 1'b1; core_addr = 8'h11;
    @(negedge clk);
    bus_xfer(BASE + 32'h014, 1'b0, 4'hF, 32'd0, r);
    chk("lit_rd_rejected", r, 32'h0000_0000);
    bus_xfer(BASE + 32'h404, 1'b0, 4'hF, 32'd0, r);
    chk("lit_status_run", r, 32'h0002_0003);

    // back to load mode; the core wrote word 0x2A with its pass-through write
    bus_xfer(BASE + 32'h400, 1'b1, 4'hF, 32'h0000_0001, r);
    ref_mem[8'h2A] = 32'h0BAD_F00D;
    bus_xfer(BASE + 32'h0A8, 1'b0, 4'hF, 32'd0, r);
    chk("lit_rd_core_word", r, 32'h0BAD_F00D);

    // reset while the read sits in RD_WAIT
    @(negedge clk);
    busy = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h014;
    @(negedge clk);
    @(negedge clk);
    chk("rdwait_no_ack", {31'd0, ack}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    chk("midrst_init_en", {31'd0, init_en}, 32'd1);
    chk("midrst_csb", {31'd0, csb}, 32'd1);
    chk("midrst_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    exp_load = 1'b1; wr_m = 9'd0; rej_m = 9'd0; exp_dat = 32'd0;
    rst_n = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    bus_xfer(BASE + 32'h404, 1'b0, 4'hF, 32'd0, r);
    chk("lit_status_after_rst", r, 32'h0000_0000);
    bus_xfer(BASE + 32'h014, 1'b0, 4'hF, 32'd0, r);
    chk("lit_rd_after_rst", r, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
